// File: rtl/spike_rate_decoder_if.sv
// Result port of the spike rate decoder: latched rates, winner, status flags
// and the valid/ready handshake of the single-entry output buffer.
interface spike_rate_decoder_if #(
  parameter int CNT_W = 5
);
  logic [4*CNT_W-1:0] rate_out;
  logic [1:0]         winner;
  logic               none;
  logic [3:0]         sat;
  logic               overrun;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output rate_out, winner, none, sat, overrun, out_valid,
    input  out_ready
  );

  modport slave (
    input  rate_out, winner, none, sat, overrun, out_valid,
    output out_ready
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes on four channels over a fixed window of
// clock cycles, then latches the counts, the winning input neuron and status
// flags into a single-entry valid/ready output buffer. Windows run
// back-to-back while enable is high; dropping enable aborts the window.
module spike_rate_decoder #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [3:0]           spike_in,
  spike_rate_decoder_if.master bus
);

  localparam int WC_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WC_W-1:0]  LAST    = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE, COUNT} state_t;

  state_t            state;
  logic [WC_W-1:0]   wcnt;
  logic [CNT_W-1:0]  cnt     [4];
  logic [3:0]        sat_acc;

  logic [CNT_W:0]     inc     [4];
  logic [CNT_W-1:0]   cnt_nxt [4];
  logic [3:0]         sat_nxt;
  logic [1:0]         win_nxt;
  logic               none_nxt;
  logic [CNT_W-1:0]   best;
  logic [4*CNT_W-1:0] rate_nxt;

  // Saturating increment; the top bit flags a spike lost at full scale.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c,
                                             input logic            s);
    if (s && (c == CNT_MAX)) return {1'b1, c};
    else if (s)              return {1'b0, c + 1'b1};
    else                     return {1'b0, c};
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_ch
    assign inc[i]     = sat_inc(cnt[i], spike_in[i]);
    assign cnt_nxt[i] = inc[i][CNT_W-1:0];
    assign sat_nxt[i] = sat_acc[i] | inc[i][CNT_W];
  end

  // Winner among input neurons 0..2 on the counts including this edge's spikes;
  // strict compares keep ties on the lowest index.
  always_comb begin
    win_nxt  = 2'd0;
    best     = cnt_nxt[0];
    if (cnt_nxt[1] > best) begin
      win_nxt = 2'd1;
      best    = cnt_nxt[1];
    end
    if (cnt_nxt[2] > best) begin
      win_nxt = 2'd2;
      best    = cnt_nxt[2];
    end
    none_nxt = (cnt_nxt[0] == '0) && (cnt_nxt[1] == '0) && (cnt_nxt[2] == '0);
    rate_nxt = {cnt_nxt[3], cnt_nxt[2], cnt_nxt[1], cnt_nxt[0]};
  end

  // Window FSM, per-channel counters and the output buffer with handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wcnt          <= '0;
      sat_acc       <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      bus.rate_out  <= '0;
      bus.winner    <= 2'd0;
      bus.none      <= 1'b0;
      bus.sat       <= 4'd0;
      bus.overrun   <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      // Acceptance frees the buffer; a load below on the same edge wins.
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            state   <= COUNT;
            wcnt    <= '0;
            sat_acc <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
          end
        end

        COUNT: begin
          if (!enable) begin
            // Abort: partial counts are dropped, output buffer untouched.
            state   <= IDLE;
            wcnt    <= '0;
            sat_acc <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
          end else if (wcnt == LAST) begin
            bus.rate_out  <= rate_nxt;
            bus.sat       <= sat_nxt;
            bus.winner    <= win_nxt;
            bus.none      <= none_nxt;
            bus.overrun   <= bus.out_valid && !bus.out_ready;
            bus.out_valid <= 1'b1;
            wcnt          <= '0;
            sat_acc       <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
          end else begin
            wcnt    <= wcnt + 1'b1;
            sat_acc <= sat_nxt;
            for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: rate decode, tie/none, back-pressure
// and overrun, abort, asynchronous reset and counter saturation.
module tb_spike_rate_decoder;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       enable2;
  logic [3:0] spike;
  logic [3:0] spike2;

  int n_tests = 0;
  int n_fail  = 0;

  spike_rate_decoder_if #(.CNT_W(5)) bus1 ();
  spike_rate_decoder_if #(.CNT_W(3)) bus2 ();

  spike_rate_decoder #(.WINDOW(W), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .spike_in (spike),
    .bus      (bus1)
  );

  spike_rate_decoder #(.WINDOW(W), .CNT_W(3)) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable2),
    .spike_in (spike2),
    .bus      (bus2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [19:0] pack5(input int c0, c1, c2, c3);
    logic [4:0] a, b, c, d;
    a = 5'(c0); b = 5'(c1); c = 5'(c2); d = 5'(c3);
    return {d, c, b, a};
  endfunction

  // Channel spikes on cycle c when it is a multiple of period p, up to l spikes.
  function automatic logic sp(input int p, input int l, input int c);
    if (p == 0) return 1'b0;
    return ((c % p) == 0) && ((c / p) < l);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [19:0] rate,
                              input int win, input bit nn, input logic [3:0] st,
                              input bit ovr, input bit vld);
    check_eq({tag, "_rate"},    bus1.rate_out,  rate);
    check_eq({tag, "_winner"},  bus1.winner,    win);
    check_eq({tag, "_none"},    bus1.none,      nn);
    check_eq({tag, "_sat"},     bus1.sat,       st);
    check_eq({tag, "_overrun"}, bus1.overrun,   ovr);
    check_eq({tag, "_valid"},   bus1.out_valid, vld);
  endtask

  // One full counting window; ready is driven per cycle as first/middle/last.
  // vcnt counts cycles before the last where out_valid was high, chg counts
  // cycles where rate_out differed from its value at window start.
  task automatic run_window(input int p0, p1, p2, p3, l0, l1, l2, l3,
                            input bit rf, rm, rl, output int vcnt, output int chg);
    logic [19:0] r0;
    r0   = bus1.rate_out;
    vcnt = 0;
    chg  = 0;
    for (int c = 0; c < W; c++) begin
      spike = {sp(p3, l3, c), sp(p2, l2, c), sp(p1, l1, c), sp(p0, l0, c)};
      bus1.out_ready = (c == 0) ? rf : ((c == W - 1) ? rl : rm);
      tick();
      if (c < W - 1) begin
        if (bus1.out_valid) vcnt++;
        if (bus1.rate_out !== r0) chg++;
      end
    end
    spike = 4'd0;
  endtask

  initial begin
    int v;
    int ch;
    reset          = 1'b1;
    enable         = 1'b0;
    enable2        = 1'b0;
    spike          = 4'd0;
    spike2         = 4'd0;
    bus1.out_ready = 1'b1;
    bus2.out_ready = 1'b1;
    #1;
    check_result("reset0", 20'd0, 0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Rate decode: ch0 every cycle, ch1 every other, ch2 never, ch3 every 4th.
    enable = 1'b1;
    tick();
    run_window(1, 2, 0, 4, 99, 99, 99, 99, 1'b1, 1'b1, 1'b1, v, ch);
    check_result("rate1", pack5(16, 8, 0, 4), 0, 1'b0, 4'd0, 1'b0, 1'b1);
    run_window(1, 2, 0, 4, 99, 99, 99, 99, 1'b1, 1'b1, 1'b1, v, ch);
    check_eq("rate2_valid_pulse", v, 0);
    check_result("rate2", pack5(16, 8, 0, 4), 0, 1'b0, 4'd0, 1'b0, 1'b1);

    // Tie between ch1 and ch2, then a window with no input-neuron spikes.
    run_window(1, 1, 1, 0, 3, 5, 5, 0, 1'b1, 1'b1, 1'b1, v, ch);
    check_result("tie", pack5(3, 5, 5, 0), 1, 1'b0, 4'd0, 1'b0, 1'b1);
    run_window(0, 0, 0, 1, 0, 0, 0, 2, 1'b1, 1'b1, 1'b1, v, ch);
    check_result("none", pack5(0, 0, 0, 2), 0, 1'b1, 4'd0, 1'b0, 1'b1);

    // Back-pressure: A held through window B, B overwrites A, C accepted on load.
    run_window(1, 0, 0, 0, 7, 0, 0, 0, 1'b1, 1'b0, 1'b0, v, ch);
    check_result("bp_a", pack5(7, 0, 0, 0), 0, 1'b0, 4'd0, 1'b0, 1'b1);
    run_window(0, 1, 1, 0, 0, 1, 9, 0, 1'b0, 1'b0, 1'b0, v, ch);
    check_eq("bp_hold_valid", v, W - 1);
    check_eq("bp_hold_stable", ch, 0);
    check_result("bp_b", pack5(0, 1, 9, 0), 2, 1'b0, 4'd0, 1'b1, 1'b1);
    run_window(0, 1, 0, 0, 0, 4, 0, 0, 1'b0, 1'b0, 1'b1, v, ch);
    check_result("bp_c", pack5(0, 4, 0, 0), 1, 1'b0, 4'd0, 1'b0, 1'b1);

    // Abort after 7 counting edges, 3 edges low, then a fresh window.
    v     = 0;
    spike = 4'b0001;
    repeat (7) begin
      tick();
      if (bus1.out_valid) v++;
    end
    enable = 1'b0;
    repeat (3) begin
      tick();
      if (bus1.out_valid) v++;
    end
    check_eq("abort_no_valid", v, 0);
    enable = 1'b1;
    tick();
    run_window(1, 1, 0, 0, 3, 99, 0, 0, 1'b1, 1'b1, 1'b1, v, ch);
    check_eq("abort_next_early_valid", v, 0);
    check_result("abort_next", pack5(3, 16, 0, 0), 1, 1'b0, 4'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-window with a pending result.
    run_window(0, 0, 1, 0, 0, 0, 2, 0, 1'b0, 1'b0, 1'b0, v, ch);
    check_eq("rst_pre_valid", bus1.out_valid, 1'b1);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check_result("rst_async", 20'd0, 0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset          = 1'b0;
    enable         = 1'b0;
    bus1.out_ready = 1'b1;
    v = 0;
    repeat (W + 2) begin
      tick();
      if (bus1.out_valid) v++;
    end
    check_eq("rst_idle_no_valid", v, 0);

    // Saturation on a 3-bit counter: ch3 every cycle, ch0 three spikes.
    enable2 = 1'b1;
    tick();
    for (int c = 0; c < W; c++) begin
      spike2 = {1'b1, 2'b00, (c < 3)};
      tick();
    end
    spike2 = 4'd0;
    check_eq("sat_rate",    bus2.rate_out,  {3'd7, 3'd0, 3'd0, 3'd3});
    check_eq("sat_flags",   bus2.sat,       4'b1000);
    check_eq("sat_winner",  bus2.winner,    0);
    check_eq("sat_none",    bus2.none,      1'b0);
    check_eq("sat_valid",   bus2.out_valid, 1'b1);
    check_eq("sat_overrun", bus2.overrun,   1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
